// File: rtl/pll_seq_pkg.sv
// rtl/pll_seq_pkg.sv - shared types and defaults for the PLL power-up/reset sequencer
package pll_seq_pkg;

  typedef enum logic [2:0] {
    ST_PD,
    ST_RST,
    ST_LOCK,
    ST_GATE,
    ST_RUN,
    ST_QUIESCE
  } seq_state_t;

  localparam logic [7:0] M_DEF = 8'h19;
  localparam logic [6:0] N_DEF = 7'h6;
  localparam logic       K_DEF = 1'b0;

  function automatic int dwell_width(input int a, input int b, input int c);
    int mx;
    mx = a;
    if (b > mx) mx = b;
    if (c > mx) mx = c;
    return (mx < 2) ? 1 : $clog2(mx);
  endfunction

  localparam int DWELL_W = dwell_width(16, 4096, 8);

endpackage

// File: rtl/pll_rst_seq.sv
// rtl/pll_rst_seq.sv - PLL power-down/reset/lock-wait sequencer with clock gate, system reset and divider reconfig
module pll_rst_seq
  import pll_seq_pkg::*;
#(
  parameter int         RST_CYC  = 16,
  parameter int         LOCK_CYC = 4096,
  parameter int         HOLD_CYC = 8,
  parameter logic [7:0] M_DEF    = pll_seq_pkg::M_DEF,
  parameter logic [6:0] N_DEF    = pll_seq_pkg::N_DEF,
  parameter logic       K_DEF    = pll_seq_pkg::K_DEF
) (
  input  logic       CLK,
  input  logic       RESETn,
  input  logic       cfg_req,
  input  logic [7:0] cfg_m,
  input  logic [6:0] cfg_n,
  input  logic       cfg_k,
  output logic       cfg_ack,
  output logic       cfg_err,
  output logic       pll_pd,
  output logic       pll_rst,
  output logic [7:0] pll_m,
  output logic [6:0] pll_n,
  output logic       pll_k,
  output logic       clk_en,
  output logic       sys_rst_n,
  output logic       locked,
  output logic       busy
);

  localparam int W = dwell_width(RST_CYC, LOCK_CYC, HOLD_CYC);

  localparam logic [W-1:0] RST_LD  = W'(RST_CYC - 1);
  localparam logic [W-1:0] LOCK_LD = W'(LOCK_CYC - 1);
  localparam logic [W-1:0] HOLD_LD = W'(HOLD_CYC - 1);
  // The reset-release cycle has no entry edge, so PD's first dwell is preloaded one higher.
  localparam logic [W-1:0] PD_FIRST = W'(RST_CYC);
  localparam logic [W-1:0] ONE      = W'(1);

  seq_state_t   state;
  logic [W-1:0] cnt;
  logic [7:0]   sh_m;
  logic [6:0]   sh_n;
  logic         sh_k;
  logic         req_block;

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state     <= ST_PD;
      cnt       <= PD_FIRST;
      pll_pd    <= 1'b1;
      pll_rst   <= 1'b1;
      pll_m     <= M_DEF;
      pll_n     <= N_DEF;
      pll_k     <= K_DEF;
      clk_en    <= 1'b0;
      sys_rst_n <= 1'b0;
      locked    <= 1'b0;
      busy      <= 1'b1;
      cfg_ack   <= 1'b0;
      cfg_err   <= 1'b0;
      sh_m      <= M_DEF;
      sh_n      <= N_DEF;
      sh_k      <= K_DEF;
      req_block <= 1'b0;
    end else begin
      cfg_ack <= 1'b0;
      cfg_err <= 1'b0;
      // A request must be seen low once after its ack before another is taken.
      if (!cfg_req) req_block <= 1'b0;

      case (state)
        ST_PD: begin
          if (cnt == '0) begin
            state  <= ST_RST;
            cnt    <= RST_LD;
            pll_pd <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_RST: begin
          if (cnt == '0) begin
            state   <= ST_LOCK;
            cnt     <= LOCK_LD;
            pll_rst <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_LOCK: begin
          if (cnt == '0) begin
            state  <= ST_GATE;
            cnt    <= HOLD_LD;
            clk_en <= 1'b1;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_GATE: begin
          if (cnt == '0) begin
            state     <= ST_RUN;
            sys_rst_n <= 1'b1;
            locked    <= 1'b1;
            busy      <= 1'b0;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        ST_RUN: begin
          if (cfg_req && !req_block) begin
            cfg_ack   <= 1'b1;
            req_block <= 1'b1;
            if (cfg_m == 8'd0 || cfg_n == 7'd0) begin
              cfg_err <= 1'b1;
            end else begin
              sh_m      <= cfg_m;
              sh_n      <= cfg_n;
              sh_k      <= cfg_k;
              state     <= ST_QUIESCE;
              cnt       <= HOLD_LD;
              sys_rst_n <= 1'b0;
              locked    <= 1'b0;
              busy      <= 1'b1;
            end
          end
        end
        ST_QUIESCE: begin
          // Dividers only move here, while the PLL is being powered down.
          if (cnt == '0) begin
            state   <= ST_PD;
            cnt     <= RST_LD;
            pll_pd  <= 1'b1;
            pll_rst <= 1'b1;
            clk_en  <= 1'b0;
            pll_m   <= sh_m;
            pll_n   <= sh_n;
            pll_k   <= sh_k;
          end else begin
            cnt <= cnt - ONE;
          end
        end
        default: begin
          state     <= ST_PD;
          cnt       <= RST_LD;
          pll_pd    <= 1'b1;
          pll_rst   <= 1'b1;
          clk_en    <= 1'b0;
          sys_rst_n <= 1'b0;
          locked    <= 1'b0;
          busy      <= 1'b1;
        end
      endcase
    end
  end

endmodule
